// File: rtl/shift_reg_tx_ctrl.sv
// Purpose : sequences load/hold/shift of a W-bit right-shift register to send each accepted word LSB-first.
// Latency : first bit one cycle after acceptance; frame = W (+1 parity) bits, then GAP idle cycles.
// Backpr. : in_ready only in IDLE; pause freezes the frame in progress (register held, no bit emitted).
//
// Build option: define SHIFT_TX_PARITY_EN to append an even-parity bit after the W data bits.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - word handshake, in_data is the word to serialise
//   pause               - consumer stall, only acts while a frame is being emitted
//   sr_load/sr_hold     - shift-register controls (load beats hold; neither = shift right)
//   sr_shift_in         - MSB fill bit (always 0), sr_load_data = in_data
//   sr_shift_out        - shift-register q[0]
//   tx_data/tx_valid    - serial stream, tx_last flags the final bit of a frame
//   busy                - controller not idle, frame_count counts completed frames (mod 256)
module shift_reg_tx_ctrl #(
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         pause,
  output logic         sr_load,
  output logic         sr_hold,
  output logic         sr_shift_in,
  output logic [W-1:0] sr_load_data,
  input  logic         sr_shift_out,
  output logic         tx_data,
  output logic         tx_valid,
  output logic         tx_last,
  output logic         busy,
  output logic [7:0]   frame_count
);

  localparam int CW = $clog2(W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2, S_GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd3} state_t;
`endif

  state_t          state, state_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            frame_done;
`ifdef SHIFT_TX_PARITY_EN
  logic            par_acc, par_acc_nxt;
`endif

  // After the final bit: go through GAP only when a gap is configured.
  localparam state_t END_STATE = (GAP > 0) ? S_GAP : S_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frame_count <= 8'd0;
`ifdef SHIFT_TX_PARITY_EN
      par_acc     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
`ifdef SHIFT_TX_PARITY_EN
      par_acc <= par_acc_nxt;
`endif
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    frame_done  = 1'b0;
    in_ready    = 1'b0;
    sr_load     = 1'b0;
    sr_hold     = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = 1'b0;
    tx_last     = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
    par_acc_nxt = par_acc;
`endif

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_load     = 1'b1;
          sr_hold     = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = S_SHIFT;
`ifdef SHIFT_TX_PARITY_EN
          par_acc_nxt = 1'b0;
`endif
        end
      end

      S_SHIFT: begin
        if (!pause) begin
          tx_valid    = 1'b1;
          tx_data     = sr_shift_out;
          sr_hold     = 1'b0;
          bit_cnt_nxt = bit_cnt + CW'(1);
`ifdef SHIFT_TX_PARITY_EN
          par_acc_nxt = par_acc ^ sr_shift_out;
          if (bit_cnt == CW'(W - 1)) begin
            state_nxt = S_PARITY;
          end
`else
          if (bit_cnt == CW'(W - 1)) begin
            tx_last     = 1'b1;
            frame_done  = 1'b1;
            gap_cnt_nxt = '0;
            state_nxt   = END_STATE;
          end
`endif
        end
      end

`ifdef SHIFT_TX_PARITY_EN
      S_PARITY: begin
        // Register stays held: the data word has already been fully shifted out.
        if (!pause) begin
          tx_valid    = 1'b1;
          tx_data     = par_acc;
          tx_last     = 1'b1;
          frame_done  = 1'b1;
          gap_cnt_nxt = '0;
          state_nxt   = END_STATE;
        end
      end
`endif

      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          state_nxt = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Reset forces the quiet output set even though state already reads IDLE.
    if (rst) begin
      in_ready = 1'b0;
      sr_load  = 1'b0;
      sr_hold  = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 1'b0;
      tx_last  = 1'b0;
    end
  end

  assign sr_shift_in  = 1'b0;
  assign sr_load_data = in_data;
  assign busy         = (state != S_IDLE) && !rst;

endmodule
